// File: rtl/vdp_cpu_port_if.sv
// Bus between the VDP CPU port and the video-memory arbiter.
// The port side (master) raises requests; the arbiter side (slave)
// answers with a one-cycle grant and, for reads, data on the next cycle.
interface vdp_cpu_port_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  vramReq;
  logic                  vramWe;
  logic [ADDR_WIDTH-1:0] vramAddress;
  logic [7:0]            vramDataOut;
  logic                  vramGrant;
  logic [7:0]            vramDataIn;

  modport master (
    output vramReq, vramWe, vramAddress, vramDataOut,
    input  vramGrant, vramDataIn
  );

  modport slave (
    input  vramReq, vramWe, vramAddress, vramDataOut,
    output vramGrant, vramDataIn
  );
endinterface

// File: rtl/vdp_cpu_port.sv
// CPU-facing access port of the VDP. Decodes the data and control ports,
// buffers data writes in a small FIFO, keeps one prefetch read pending and
// arbitrates both onto the VRAM bus, writes always ahead of the prefetch.
module vdp_cpu_port #(
  parameter int FIFO_DEPTH      = 4,
  parameter int ADDR_WIDTH      = 14,
  parameter int REG_INDEX_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cpuSelect,
  input  logic                       cpuWrite,
  input  logic                       cpuRead,
  input  logic                       cpuPort,
  input  logic [7:0]                 cpuDataIn,
  output logic [7:0]                 cpuDataOut,
  output logic                       cpuWait,
  output logic                       overflow,
  vdp_cpu_port_if.master             vram,
  output logic                       regWrite,
  output logic [REG_INDEX_WIDTH-1:0] regIndex,
  output logic [7:0]                 regData
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {FIRST, SECOND} phase_t;
  typedef enum logic [1:0] {IDLE, WRITE_REQ, READ_REQ, READ_WAIT} arbState_t;

  phase_t                phase;
  arbState_t             state, stateNext;
  logic [7:0]            ctrlLatch;
  logic [ADDR_WIDTH-1:0] addrPtr;
  logic [7:0]            readBuffer;
  logic                  pending;
  logic [ADDR_WIDTH-1:0] pendAddr;

  logic [ADDR_WIDTH+7:0] fifoMem [FIFO_DEPTH];
  logic [PW-1:0]         wrPtr, rdPtr;
  logic [CW-1:0]         fifoCount, countNext;
  logic [ADDR_WIDTH+7:0] fifoHead;

  logic                  dataWrite, dataRead, dataAccess, ctrlWrite, ctrlSecond;
  logic                  fifoFull, push, pop, prefetchDone;
  logic                  queueReq;
  logic [ADDR_WIDTH-1:0] queueAddr, newAddr;

  // Bus decode; a simultaneous read and write is treated as a write
  assign dataWrite  = cpuSelect & cpuWrite & ~cpuPort;
  assign dataRead   = cpuSelect & cpuRead & ~cpuWrite & ~cpuPort;
  assign dataAccess = dataWrite | dataRead;
  assign ctrlWrite  = cpuSelect & cpuWrite & cpuPort;
  assign ctrlSecond = ctrlWrite & (phase == SECOND);
  assign newAddr    = ADDR_WIDTH'({cpuDataIn[5:0], ctrlLatch});

  assign fifoFull     = (fifoCount == DEPTH_C);
  assign push         = dataWrite & ~fifoFull;
  assign pop          = (state == WRITE_REQ) & vram.vramGrant;
  assign prefetchDone = (state == READ_REQ) & vram.vramGrant;
  assign fifoHead     = fifoMem[rdPtr];
  assign cpuDataOut   = readBuffer;

  // Prefetch source: a mode-00 address set, or the address after a data read
  always_comb begin
    queueReq  = 1'b0;
    queueAddr = pendAddr;
    if (ctrlSecond && cpuDataIn[7:6] == 2'b00) begin
      queueReq  = 1'b1;
      queueAddr = newAddr;
    end else if (dataRead) begin
      queueReq  = 1'b1;
      queueAddr = addrPtr + 1'b1;
    end
  end

  // Two-byte control sequence tracking; any data access resynchronises it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase     <= FIRST;
      ctrlLatch <= 8'h00;
    end else if (dataAccess) begin
      phase <= FIRST;
    end else if (ctrlWrite) begin
      if (phase == FIRST) begin
        ctrlLatch <= cpuDataIn;
        phase     <= SECOND;
      end else begin
        phase <= FIRST;
      end
    end
  end

  // Address pointer: loaded by control modes 00/01, bumped by accepted data accesses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addrPtr <= '0;
    end else if (ctrlSecond && !cpuDataIn[7]) begin
      addrPtr <= newAddr;
    end else if (push || dataRead) begin
      addrPtr <= addrPtr + 1'b1;
    end
  end

  // Register write pulse; index and value stay on the outputs afterwards
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regWrite <= 1'b0;
      regIndex <= '0;
      regData  <= 8'h00;
    end else begin
      regWrite <= ctrlSecond && (cpuDataIn[7:6] == 2'b10);
      if (ctrlSecond && cpuDataIn[7:6] == 2'b10) begin
        regIndex <= cpuDataIn[REG_INDEX_WIDTH-1:0];
        regData  <= ctrlLatch;
      end
    end
  end

  // Next FIFO occupancy, used to keep cpuWait aligned with the count register
  always_comb begin
    countNext = fifoCount;
    if (push && !pop) countNext = fifoCount + 1'b1;
    else if (!push && pop) countNext = fifoCount - 1'b1;
  end

  // FIFO storage; contents only matter while the count says they are valid
  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= {addrPtr, cpuDataIn};
  end

  // FIFO pointers, count, wait flag and the sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
      cpuWait   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) rdPtr <= rdPtr + 1'b1;
      fifoCount <= countNext;
      cpuWait   <= (countNext == DEPTH_C);
      if (dataWrite && fifoFull) overflow <= 1'b1;
    end
  end

  // Single pending prefetch; a new request overrides the one being retired
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= 1'b0;
      pendAddr <= '0;
    end else begin
      if (prefetchDone) pending <= 1'b0;
      if (queueReq) begin
        pending  <= 1'b1;
        pendAddr <= queueAddr;
      end
    end
  end

  // Arbiter state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= stateNext;
  end

  // Arbiter next state and bus outputs; writes are served before the prefetch
  always_comb begin
    stateNext        = state;
    vram.vramReq     = 1'b0;
    vram.vramWe      = 1'b0;
    vram.vramAddress = '0;
    vram.vramDataOut = 8'h00;
    case (state)
      IDLE: begin
        if (fifoCount != '0) stateNext = WRITE_REQ;
        else if (pending) stateNext = READ_REQ;
      end
      WRITE_REQ: begin
        vram.vramReq     = 1'b1;
        vram.vramWe      = 1'b1;
        vram.vramAddress = fifoHead[ADDR_WIDTH+7:8];
        vram.vramDataOut = fifoHead[7:0];
        if (vram.vramGrant) stateNext = IDLE;
      end
      READ_REQ: begin
        vram.vramReq     = 1'b1;
        vram.vramAddress = pendAddr;
        if (vram.vramGrant) stateNext = READ_WAIT;
      end
      READ_WAIT: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Capture returned read data the cycle after the read grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) readBuffer <= 8'h00;
    else if (state == READ_WAIT) readBuffer <= vram.vramDataIn;
  end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed self-checking bench for vdp_cpu_port: control sequences, write
// FIFO draining, prefetch reads with address wrap, FIFO full/overflow,
// phase resynchronisation, write-before-read ordering and async reset.
module tb_vdp_cpu_port;

  logic       clk;
  logic       reset;
  logic       cpuSelect, cpuWrite, cpuRead, cpuPort;
  logic [7:0] cpuDataIn;
  logic [7:0] cpuDataOut;
  logic       cpuWait, overflow;
  logic       regWrite;
  logic [2:0] regIndex;
  logic [7:0] regData;

  int passCount  = 0;
  int checkCount = 0;

  vdp_cpu_port_if #(.ADDR_WIDTH(14)) vramBus ();

  vdp_cpu_port #(
    .FIFO_DEPTH(4),
    .ADDR_WIDTH(14),
    .REG_INDEX_WIDTH(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpuSelect  (cpuSelect),
    .cpuWrite   (cpuWrite),
    .cpuRead    (cpuRead),
    .cpuPort    (cpuPort),
    .cpuDataIn  (cpuDataIn),
    .cpuDataOut (cpuDataOut),
    .cpuWait    (cpuWait),
    .overflow   (overflow),
    .vram       (vramBus),
    .regWrite   (regWrite),
    .regIndex   (regIndex),
    .regData    (regData)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and reports tag/observed/expected on failure
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // One-cycle CPU access; called and returns 1 time unit after a rising edge
  task automatic applyStimulus(input bit isWrite, input bit port, input logic [7:0] data);
    cpuSelect = 1'b1;
    cpuWrite  = isWrite;
    cpuRead   = ~isWrite;
    cpuPort   = port;
    cpuDataIn = data;
    @(posedge clk); #1;
    cpuSelect = 1'b0;
    cpuWrite  = 1'b0;
    cpuRead   = 1'b0;
    cpuDataIn = 8'h00;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Bounded wait for a VRAM request; an expired bound is a failed check
  task automatic waitReq(input string tag);
    for (int i = 0; i < 10 && vramBus.vramReq !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    checkOutput(tag, vramBus.vramReq, 1);
  endtask

  // One-cycle grant; read data stays on the bus for the following cycle
  task automatic giveGrant(input logic [7:0] data);
    vramBus.vramGrant  = 1'b1;
    vramBus.vramDataIn = data;
    @(posedge clk); #1;
    vramBus.vramGrant  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cpuSelect = 1'b0; cpuWrite = 1'b0; cpuRead = 1'b0; cpuPort = 1'b0;
    cpuDataIn = 8'h00;
    vramBus.vramGrant = 1'b0;
    vramBus.vramDataIn = 8'h00;
    idleCycles(2);

    // Reset state
    checkOutput("rstReq", vramBus.vramReq, 0);
    checkOutput("rstDataOut", cpuDataOut, 8'h00);
    checkOutput("rstWait", cpuWait, 0);
    checkOutput("rstOverflow", overflow, 0);
    checkOutput("rstRegWrite", regWrite, 0);
    reset = 1'b0;
    idleCycles(1);

    // Address 0x1234 via mode 01, then two buffered data writes
    applyStimulus(1, 1, 8'h34);
    applyStimulus(1, 1, 8'h52);
    applyStimulus(1, 0, 8'hAA);
    applyStimulus(1, 0, 8'hBB);
    checkOutput("fifoCount2", dut.fifoCount, 2);
    waitReq("wr1Req");
    checkOutput("wr1We", vramBus.vramWe, 1);
    checkOutput("wr1Addr", vramBus.vramAddress, 14'h1234);
    checkOutput("wr1Data", vramBus.vramDataOut, 8'hAA);
    giveGrant(8'h00);
    checkOutput("idleBetween", vramBus.vramReq, 0);
    waitReq("wr2Req");
    checkOutput("wr2Addr", vramBus.vramAddress, 14'h1235);
    checkOutput("wr2Data", vramBus.vramDataOut, 8'hBB);
    giveGrant(8'h00);
    checkOutput("addrPtrAfterWrites", dut.addrPtr, 14'h1236);

    // Register write: value 0x07 into register 3
    applyStimulus(1, 1, 8'h07);
    applyStimulus(1, 1, 8'h83);
    checkOutput("regWritePulse", regWrite, 1);
    checkOutput("regIndex", regIndex, 3);
    checkOutput("regData", regData, 8'h07);
    idleCycles(1);
    checkOutput("regWriteSingle", regWrite, 0);
    checkOutput("regNoVram", vramBus.vramReq, 0);

    // Prefetch at 0x3FFF, data read, then wrapped prefetch at 0x0000
    applyStimulus(1, 1, 8'hFF);
    applyStimulus(1, 1, 8'h3F);
    waitReq("pf1Req");
    checkOutput("pf1We", vramBus.vramWe, 0);
    checkOutput("pf1Addr", vramBus.vramAddress, 14'h3FFF);
    giveGrant(8'h5C);
    checkOutput("bufBeforeCapture", cpuDataOut, 8'h00);
    idleCycles(1);
    checkOutput("bufCaptured", cpuDataOut, 8'h5C);
    applyStimulus(0, 0, 8'h00);
    waitReq("pf2Req");
    checkOutput("pf2AddrWrap", vramBus.vramAddress, 14'h0000);
    checkOutput("oldBufWhilePending", cpuDataOut, 8'h5C);
    giveGrant(8'h11);
    idleCycles(1);
    checkOutput("pf2Buf", cpuDataOut, 8'h11);

    // Fill the FIFO at 0x2000 with grants held off; fifth byte is dropped
    applyStimulus(1, 1, 8'h00);
    applyStimulus(1, 1, 8'h60);
    applyStimulus(1, 0, 8'h01);
    applyStimulus(1, 0, 8'h02);
    applyStimulus(1, 0, 8'h03);
    checkOutput("waitAfter3", cpuWait, 0);
    applyStimulus(1, 0, 8'h04);
    checkOutput("waitAfter4", cpuWait, 1);
    checkOutput("noOverflowYet", overflow, 0);
    applyStimulus(1, 0, 8'h05);
    checkOutput("overflowSet", overflow, 1);
    checkOutput("addrPtrHeld", dut.addrPtr, 14'h2004);
    checkOutput("fullHeadAddr", vramBus.vramAddress, 14'h2000);
    checkOutput("fullHeadData", vramBus.vramDataOut, 8'h01);
    giveGrant(8'h00);
    checkOutput("waitDropped", cpuWait, 0);
    for (int i = 1; i < 4; i++) begin
      waitReq("drainReq");
      checkOutput("drainAddr", vramBus.vramAddress, 32'h2000 + i);
      checkOutput("drainData", vramBus.vramDataOut, i + 1);
      giveGrant(8'h00);
    end
    checkOutput("overflowSticky", overflow, 1);

    // Lone first control byte, then a data write resynchronises the phase
    applyStimulus(1, 1, 8'h10);
    applyStimulus(1, 0, 8'h99);
    applyStimulus(1, 1, 8'h00);
    applyStimulus(1, 1, 8'h40);
    checkOutput("phaseResetAddr", dut.addrPtr, 14'h0000);
    waitReq("resyncWrReq");
    checkOutput("resyncWrAddr", vramBus.vramAddress, 14'h2004);
    checkOutput("resyncWrData", vramBus.vramDataOut, 8'h99);
    giveGrant(8'h00);
    idleCycles(2);
    checkOutput("noStrayPrefetch", vramBus.vramReq, 0);

    // Write 0x77 to 0x0100, then prefetch 0x0100: write must go first
    applyStimulus(1, 1, 8'h00);
    applyStimulus(1, 1, 8'h41);
    applyStimulus(1, 0, 8'h77);
    applyStimulus(1, 1, 8'h00);
    applyStimulus(1, 1, 8'h01);
    waitReq("rawWrReq");
    checkOutput("rawWrWe", vramBus.vramWe, 1);
    checkOutput("rawWrAddr", vramBus.vramAddress, 14'h0100);
    giveGrant(8'h00);
    waitReq("rawRdReq");
    checkOutput("rawRdWe", vramBus.vramWe, 0);
    checkOutput("rawRdAddr", vramBus.vramAddress, 14'h0100);
    giveGrant(8'h77);
    idleCycles(1);
    checkOutput("rawBuf", cpuDataOut, 8'h77);

    // Async reset while a read request is on the bus
    applyStimulus(0, 0, 8'h00);
    waitReq("abortReq");
    #2 reset = 1'b1;
    #1;
    checkOutput("abortReqLow", vramBus.vramReq, 0);
    checkOutput("abortAddr", vramBus.vramAddress, 0);
    checkOutput("abortDataOut", cpuDataOut, 8'h00);
    checkOutput("abortOverflow", overflow, 0);
    checkOutput("abortRegIndex", regIndex, 0);
    checkOutput("abortRegData", regData, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    idleCycles(3);
    checkOutput("abortNoResume", vramBus.vramReq, 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
